// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard logic.
package pipe_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ERR
  } mem_state_t;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/forward_unit.sv
// Operand-forward select for one source register in E; M beats W, x0 never forwards.
module forward_unit
  import pipe_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] waddr_m,
  input  logic       reg_wr_m,
  input  logic [4:0] waddr_w,
  input  logic       reg_wr_w,
  output fwd_sel_t   sel
);

  always_comb begin
    // NOTE: default first so every path assigns sel and no latch is inferred.
    sel = FWD_RF;
    if (reg_wr_m && waddr_m != REG_X0 && waddr_m == rs) begin
      sel = FWD_M;
    end else if (reg_wr_w && waddr_w != REG_X0 && waddr_w == rs) begin
      sel = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Stall/flush/forward sequencer for the 5-stage pipeline, with data-memory
// handshake, timeout and stall/flush performance counters.
module hazard_controller
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1D,
  input  logic [4:0]       rs2D,
  input  logic [4:0]       rs1E,
  input  logic [4:0]       rs2E,
  input  logic [4:0]       waddrE,
  input  logic [4:0]       waddrM,
  input  logic [4:0]       waddrW,
  input  logic             reg_wrE,
  input  logic             reg_wrM,
  input  logic             reg_wrW,
  input  logic             loadE,
  input  logic             pc_srcE,
  input  logic             mem_reqM,
  input  logic             dmem_ack,
  output logic             dmem_req,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             StallW,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  mem_state_t state, state_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       mstall;
  logic       lu;
  logic       any_stall;
  logic       any_flush;
  fwd_sel_t   fwd_a, fwd_b;

  forward_unit u_fwd_a (
    .rs       (rs1E),
    .waddr_m  (waddrM),
    .reg_wr_m (reg_wrM),
    .waddr_w  (waddrW),
    .reg_wr_w (reg_wrW),
    .sel      (fwd_a)
  );

  forward_unit u_fwd_b (
    .rs       (rs2E),
    .waddr_m  (waddrM),
    .reg_wr_m (reg_wrM),
    .waddr_w  (waddrW),
    .reg_wr_w (reg_wrW),
    .sel      (fwd_b)
  );

  assign ForwardAE = fwd_a;
  assign ForwardBE = fwd_b;

  // reg_wrE only qualifies ALU results, which forwarding covers; a load in E cannot.
  assign lu = loadE && (waddrE != REG_X0) && ((waddrE == rs1D) || (waddrE == rs2D));

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking so every register samples pre-edge values regardless of block order.
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    // rst gates the request so it drops the moment reset asserts, not at the next edge.
    dmem_req     = 1'b0;
    case (state)
      IDLE: begin
        dmem_req = mem_reqM && !rst;
        if (mem_reqM && !dmem_ack) begin
          state_nxt    = WAIT;
          wait_cnt_nxt = 8'd1;
        end
      end
      WAIT: begin
        dmem_req = !rst;
        if (dmem_ack) begin
          state_nxt    = IDLE;
          wait_cnt_nxt = 8'd0;
        end else if (wait_cnt == TIMEOUT) begin
          state_nxt = ERR;
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end
      ERR:     state_nxt = ERR;
      default: state_nxt = IDLE;
    endcase
  end

  assign mstall  = (dmem_req && !dmem_ack) || (state == ERR);
  assign mem_err = (state == ERR);

  // A frozen pipeline keeps pc_srcE and lu stable, so deferring them loses nothing.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    StallW = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    if (mstall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      StallW = 1'b1;
    end else if (pc_srcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (lu) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  assign any_stall = StallF | StallD | StallE | StallM | StallW;
  assign any_flush = FlushD | FlushE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (any_stall) stall_cnt <= stall_cnt + CNT_W'(1);
      if (any_flush) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed scenarios plus a
// randomized run against a cycle-level behavioural model.
module tb_hazard_controller;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1D, rs2D, rs1E, rs2E, waddrE, waddrM, waddrW;
  logic        reg_wrE, reg_wrM, reg_wrW, loadE, pc_srcE, mem_reqM, dmem_ack;
  logic        dmem_req, StallF, StallD, StallE, StallM, StallW, FlushD, FlushE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        mem_err;
  logic [31:0] stall_cnt, flush_cnt;
  logic [7:0]  ctl_obs;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // model: consecutive unacknowledged request cycles, error flag, counters
  int          m_waited;
  bit          m_err;
  logic [31:0] m_stall_cnt, m_flush_cnt;

  hazard_controller #(.MEM_TIMEOUT(T), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
    .waddrE(waddrE), .waddrM(waddrM), .waddrW(waddrW),
    .reg_wrE(reg_wrE), .reg_wrM(reg_wrM), .reg_wrW(reg_wrW),
    .loadE(loadE), .pc_srcE(pc_srcE), .mem_reqM(mem_reqM), .dmem_ack(dmem_ack),
    .dmem_req(dmem_req),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
    .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // {StallF,StallD,StallE,StallM,StallW,FlushD,FlushE,dmem_req}
  assign ctl_obs = {StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, dmem_req};

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (reg_wrM && waddrM != 0 && waddrM == rs) return 2'b10;
    if (reg_wrW && waddrW != 0 && waddrW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [7:0] ref_ctl();
    logic req, hold, lu;
    req  = !rst && !m_err && (m_waited > 0 || mem_reqM);
    hold = !rst && (m_err || (req && !dmem_ack));
    lu   = loadE && waddrE != 0 && (waddrE == rs1D || waddrE == rs2D);
    if (hold)    return {5'b11111, 2'b00, req};
    if (pc_srcE) return {5'b00000, 2'b11, req};
    if (lu)      return {5'b11000, 2'b01, req};
    return {7'b0, req};
  endfunction

  task automatic quiet();
    {rs1D, rs2D, rs1E, rs2E, waddrE, waddrM, waddrW} = '0;
    {reg_wrE, reg_wrM, reg_wrW, loadE, pc_srcE, mem_reqM, dmem_ack} = '0;
  endtask

  task automatic model_clear();
    m_waited    = 0;
    m_err       = 1'b0;
    m_stall_cnt = '0;
    m_flush_cnt = '0;
  endtask

  // advance one clock edge, updating the model with the pre-edge inputs
  task automatic tick();
    logic [7:0] c;
    c = ref_ctl();
    @(posedge clk);
    if (!rst) begin
      if (c[7:3] != 0) m_stall_cnt = m_stall_cnt + 32'd1;
      if (c[2:1] != 0) m_flush_cnt = m_flush_cnt + 32'd1;
      if (!m_err && c[0]) begin
        if (dmem_ack) m_waited = 0;
        else begin
          m_waited++;
          if (m_waited > T) m_err = 1'b1;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    quiet();
    rst = 1'b1;
    model_clear();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    chk_cnt++;
    if (ctl_obs !== 8'h00) $display("FAIL reset_ctl: got %b expected %b", ctl_obs, 8'h00);
    else pass_cnt++;
    chk_cnt++;
    if (mem_err !== 1'b0 || stall_cnt !== 32'd0 || flush_cnt !== 32'd0)
      $display("FAIL reset_state: got err=%b sc=%0d fc=%0d expected 0/0/0", mem_err, stall_cnt, flush_cnt);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_forward();
    rs1E = 5; waddrM = 5; reg_wrM = 1; waddrW = 5; reg_wrW = 1;
    @(negedge clk);
    chk_cnt++;
    if (ForwardAE !== 2'b10) $display("FAIL fwd_m_wins: got %b expected 10", ForwardAE);
    else pass_cnt++;
    tick();
    reg_wrM = 0;
    @(negedge clk);
    chk_cnt++;
    if (ForwardAE !== 2'b01) $display("FAIL fwd_w: got %b expected 01", ForwardAE);
    else pass_cnt++;
    tick();
    rs1E = 0; rs2E = 0; waddrM = 0; waddrW = 0; reg_wrM = 1; reg_wrW = 1;
    @(negedge clk);
    chk_cnt++;
    if (ForwardAE !== 2'b00 || ForwardBE !== 2'b00)
      $display("FAIL fwd_x0: got %b/%b expected 00/00", ForwardAE, ForwardBE);
    else pass_cnt++;
    tick();
    rs2E = 7; waddrW = 7; waddrM = 6;
    @(negedge clk);
    chk_cnt++;
    if (ForwardBE !== 2'b01) $display("FAIL fwd_b_w: got %b expected 01", ForwardBE);
    else pass_cnt++;
    tick();
    quiet();
  endtask

  task automatic test_load_use();
    logic [31:0] s0, f0;
    s0 = m_stall_cnt; f0 = m_flush_cnt;
    loadE = 1; waddrE = 3; rs2D = 3; rs1D = 1;
    @(negedge clk);
    chk_cnt++;
    if (ctl_obs !== 8'b1100_0010) $display("FAIL load_use: got %b expected %b", ctl_obs, 8'b1100_0010);
    else pass_cnt++;
    tick();
    loadE = 0;
    @(negedge clk);
    chk_cnt++;
    if (ctl_obs !== 8'h00) $display("FAIL load_use_after: got %b expected %b", ctl_obs, 8'h00);
    else pass_cnt++;
    chk_cnt++;
    if (stall_cnt !== s0 + 32'd1 || flush_cnt !== f0 + 32'd1)
      $display("FAIL load_use_cnt: got %0d/%0d expected %0d/%0d", stall_cnt, flush_cnt, s0 + 1, f0 + 1);
    else pass_cnt++;
    tick();
    quiet();
  endtask

  task automatic test_branch_lu();
    loadE = 1; waddrE = 3; rs1D = 3; pc_srcE = 1;
    @(negedge clk);
    chk_cnt++;
    if (ctl_obs !== 8'b0000_0110) $display("FAIL branch_over_lu: got %b expected %b", ctl_obs, 8'b0000_0110);
    else pass_cnt++;
    tick();
    quiet();
  endtask

  task automatic test_mem_wait();
    mem_reqM = 1;
    for (int i = 1; i <= 4; i++) begin
      dmem_ack = (i == 4);
      @(negedge clk);
      chk_cnt++;
      if (ctl_obs !== ((i == 4) ? 8'b0000_0001 : 8'b1111_1001))
        $display("FAIL mem_wait_c%0d: got %b expected %b", i, ctl_obs, (i == 4) ? 8'b0000_0001 : 8'b1111_1001);
      else pass_cnt++;
      tick();
    end
    quiet();
    @(negedge clk);
    chk_cnt++;
    if (ctl_obs !== 8'h00 || mem_err !== 1'b0)
      $display("FAIL mem_wait_idle: got %b err=%b expected 00000000 err=0", ctl_obs, mem_err);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_deferred_branch();
    mem_reqM = 1; pc_srcE = 1;
    for (int i = 1; i <= 3; i++) begin
      dmem_ack = (i == 3);
      @(negedge clk);
      chk_cnt++;
      if (ctl_obs !== ((i == 3) ? 8'b0000_0111 : 8'b1111_1001))
        $display("FAIL deferred_branch_c%0d: got %b expected %b", i, ctl_obs, (i == 3) ? 8'b0000_0111 : 8'b1111_1001);
      else pass_cnt++;
      tick();
    end
    quiet();
  endtask

  task automatic test_timeout();
    mem_reqM = 1;
    for (int i = 1; i <= 8; i++) begin
      if (i > 6) mem_reqM = 0;
      @(negedge clk);
      chk_cnt++;
      if (ctl_obs !== ((i <= T + 1) ? 8'b1111_1001 : 8'b1111_1000) || mem_err !== (i > T + 1))
        $display("FAIL timeout_c%0d: got %b err=%b expected %b err=%b", i, ctl_obs, mem_err,
                 (i <= T + 1) ? 8'b1111_1001 : 8'b1111_1000, i > T + 1);
      else pass_cnt++;
      tick();
    end
    #2 rst = 1'b1;
    model_clear();
    #1;
    chk_cnt++;
    if (ctl_obs !== 8'h00 || mem_err !== 1'b0 || stall_cnt !== 32'd0 || flush_cnt !== 32'd0)
      $display("FAIL async_reset_err: got %b err=%b sc=%0d fc=%0d expected all zero", ctl_obs, mem_err, stall_cnt, flush_cnt);
    else pass_cnt++;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    mem_reqM = 1;
    tick();
    tick();
    #2 rst = 1'b1;
    model_clear();
    #1;
    chk_cnt++;
    if (dmem_req !== 1'b0) $display("FAIL reset_mid_wait_req: got %b expected 0", dmem_req);
    else pass_cnt++;
    dmem_ack = 1;
    @(posedge clk);
    #1 rst = 1'b0;
    quiet();
    @(negedge clk);
    chk_cnt++;
    if (ctl_obs !== 8'h00 || stall_cnt !== 32'd0)
      $display("FAIL reset_mid_wait_idle: got %b sc=%0d expected 00000000 sc=0", ctl_obs, stall_cnt);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_random();
    logic [7:0] exp_ctl;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if (m_err && ($urandom_range(0, 3) == 0)) do_reset();
      rs1D = 5'($urandom_range(0, 3));  rs2D = 5'($urandom_range(0, 3));
      rs1E = 5'($urandom_range(0, 3));  rs2E = 5'($urandom_range(0, 3));
      waddrE = 5'($urandom_range(0, 3)); waddrM = 5'($urandom_range(0, 3));
      waddrW = 5'($urandom_range(0, 3));
      reg_wrE = 1'($urandom); reg_wrM = 1'($urandom); reg_wrW = 1'($urandom);
      loadE = ($urandom_range(0, 2) == 0);
      pc_srcE = ($urandom_range(0, 4) == 0);
      mem_reqM = ($urandom_range(0, 2) == 0);
      dmem_ack = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      exp_ctl = ref_ctl();
      chk_cnt++;
      if (ctl_obs !== exp_ctl) $display("FAIL rand_ctl[%0d]: got %b expected %b", n, ctl_obs, exp_ctl);
      else pass_cnt++;
      chk_cnt++;
      if (ForwardAE !== ref_fwd(rs1E) || ForwardBE !== ref_fwd(rs2E))
        $display("FAIL rand_fwd[%0d]: got %b/%b expected %b/%b", n, ForwardAE, ForwardBE, ref_fwd(rs1E), ref_fwd(rs2E));
      else pass_cnt++;
      chk_cnt++;
      if (mem_err !== m_err || stall_cnt !== m_stall_cnt || flush_cnt !== m_flush_cnt)
        $display("FAIL rand_state[%0d]: got err=%b sc=%0d fc=%0d expected err=%b sc=%0d fc=%0d",
                 n, mem_err, stall_cnt, flush_cnt, m_err, m_stall_cnt, m_flush_cnt);
      else pass_cnt++;
      tick();
    end
    quiet();
  endtask

  initial begin
    rst = 1'b0;
    quiet();
    model_clear();
    #2;
    test_reset();
    test_forward();
    test_load_use();
    test_branch_lu();
    test_mem_wait();
    test_deferred_branch();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
